// File: rtl/mdu_iterative_if.sv
// ============================================================================
// Module : mdu_iterative_if
// Brief  : Issue/result bundle between the execute stage and mdu_iterative.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdu_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_Start;
  logic [2:0]            i_Op;
  logic [DATA_WIDTH-1:0] i_SrcA;
  logic [DATA_WIDTH-1:0] i_SrcB;
  logic                  i_Kill;
  logic                  i_ReadHiLoD;
  logic                  o_Busy;
  logic                  o_Done;
  logic                  o_StallD;
  logic [DATA_WIDTH-1:0] o_HI;
  logic [DATA_WIDTH-1:0] o_LO;

  modport master (
    output i_Start, i_Op, i_SrcA, i_SrcB, i_Kill, i_ReadHiLoD,
    input  o_Busy, o_Done, o_StallD, o_HI, o_LO
  );

  modport slave (
    input  i_Start, i_Op, i_SrcA, i_SrcB, i_Kill, i_ReadHiLoD,
    output o_Busy, o_Done, o_StallD, o_HI, o_LO
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iterative.sv
// ============================================================================
// Module : mdu_iterative
// Brief  : Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
//          Optional macro MDU_EARLY_OUT_EN: multiply finishes once the
//          remaining multiplier bits are all zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  wire logic         i_CLK,
  input  wire logic         i_RST,
  mdu_iterative_if.slave    bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ITER = 2'd1;
  localparam logic [1:0] c_POST = 2'd2;

  localparam logic [2:0] c_OP_MTHI = 3'b100;
  localparam logic [2:0] c_OP_MTLO = 3'b101;

  localparam int c_W = DATA_WIDTH;

  logic [1:0]          r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                r_is_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_div0;
  logic [2*c_W-1:0]    r_a;
  logic [c_W-1:0]      r_b;
  logic [2*c_W-1:0]    r_acc;
  logic [c_W-1:0]      r_hi;
  logic [c_W-1:0]      r_lo;
  logic                r_done;

  logic                w_busy;
  logic                w_is_muldiv;
  logic                w_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [c_W-1:0]      w_a_abs;
  logic [c_W-1:0]      w_b_abs;
  logic [c_W:0]        w_trial;
  logic [c_W-1:0]      w_b_next;
  logic                w_last;
  logic [2*c_W-1:0]    w_prod;
  logic [c_W-1:0]      w_quot;
  logic [c_W-1:0]      w_rem;

  assign w_busy      = (r_state != c_IDLE);
  assign w_is_muldiv = ~bus.i_Op[2];
  assign w_signed    = ~bus.i_Op[0];
  assign w_a_neg     = w_signed & bus.i_SrcA[c_W-1];
  assign w_b_neg     = w_signed & bus.i_SrcB[c_W-1];
  assign w_a_abs     = w_a_neg ? -bus.i_SrcA : bus.i_SrcA;
  assign w_b_abs     = w_b_neg ? -bus.i_SrcB : bus.i_SrcB;

  // Restoring step: the bit shifted out of the remainder joins the trial.
  assign w_trial  = r_a[2*c_W-1:c_W-1] - {1'b0, r_b};
  assign w_b_next = r_b >> 1;

`ifdef MDU_EARLY_OUT_EN
  assign w_last = (r_cnt == CNT_WIDTH'(1)) | (~r_is_div & (w_b_next == '0));
`else
  assign w_last = (r_cnt == CNT_WIDTH'(1));
`endif

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_a[c_W-1:0] : r_a[c_W-1:0];
  // With a zero divisor the remainder ends as |SrcA|; restoring its sign
  // reproduces SrcA exactly, including the most-negative value.
  assign w_rem  = r_neg_rem ? -r_a[2*c_W-1:c_W] : r_a[2*c_W-1:c_W];

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.i_Start && !bus.i_Kill) begin
            if (w_is_muldiv) begin
              r_is_div  <= bus.i_Op[1];
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_div0    <= (bus.i_SrcB == '0);
              r_a       <= {{c_W{1'b0}}, w_a_abs};
              r_b       <= w_b_abs;
              r_acc     <= '0;
              r_cnt     <= CNT_WIDTH'(DATA_WIDTH);
              r_state   <= c_ITER;
            end else if (bus.i_Op == c_OP_MTHI) begin
              r_hi <= bus.i_SrcA;
            end else if (bus.i_Op == c_OP_MTLO) begin
              r_lo <= bus.i_SrcA;
            end
          end
        end
        c_ITER: begin
          if (bus.i_Kill) begin
            r_state <= c_IDLE;
          end else begin
            if (r_is_div) begin
              if (!w_trial[c_W])
                r_a <= {w_trial[c_W-1:0], r_a[c_W-2:0], 1'b1};
              else
                r_a <= {r_a[2*c_W-2:0], 1'b0};
            end else begin
              if (r_b[0])
                r_acc <= r_acc + r_a;
              r_a <= {r_a[2*c_W-2:0], 1'b0};
              r_b <= w_b_next;
            end
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (w_last)
              r_state <= c_POST;
          end
        end
        c_POST: begin
          if (!bus.i_Kill) begin
            if (!r_is_div) begin
              r_hi <= w_prod[2*c_W-1:c_W];
              r_lo <= w_prod[c_W-1:0];
            end else if (r_div0) begin
              r_hi <= w_rem;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
            r_done <= 1'b1;
          end
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.o_Busy   = w_busy;
  assign bus.o_Done   = r_done;
  assign bus.o_StallD = w_busy & (bus.i_Start | bus.i_ReadHiLoD);
  assign bus.o_HI     = r_hi;
  assign bus.o_LO     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// ============================================================================
// Module : tb_mdu_iterative
// Brief  : Directed + random checks of mdu_iterative against a plain
//          arithmetic reference (honours MDU_EARLY_OUT_EN for latency).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_iterative;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iterative_if #(.DATA_WIDTH(W)) u_if ();

  mdu_iterative #(.DATA_WIDTH(W)) u_dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Returns {HI, LO} as the architecture defines them.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
    logic [W-1:0] m;
    m = (op == 3'd0 && b[W-1]) ? -b : b;
    if (op[1]) return W + 1;
`ifdef MDU_EARLY_OUT_EN
    if (m == 0) return 2;
    for (int i = W - 1; i >= 0; i--)
      if (m[i]) return i + 2;
`else
    if (m == 0) return W + 1;
`endif
    return W + 1;
  endfunction

  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      if (u_if.o_Busy) busy_n++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!u_if.o_Done && n < 200);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n, busy_n;
    logic [63:0] r;
    @(negedge clk);
    u_if.i_Start = 1'b1;
    u_if.i_Op    = op;
    u_if.i_SrcA  = a;
    u_if.i_SrcB  = b;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Start = 1'b0;
    if (!op[2]) begin
      wait_done(n, busy_n);
      r = ref_result(op, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check({tag, "_lat"}, n, ref_latency(op, b));
      check({tag, "_busycyc"}, busy_n, ref_latency(op, b));
      check({tag, "_hi"}, u_if.o_HI, exp_hi);
      check({tag, "_lo"}, u_if.o_LO, exp_lo);
      check({tag, "_busy_end"}, u_if.o_Busy, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, u_if.o_Done, 0);
    end else begin
      if (op == 3'd4) exp_hi = a;
      if (op == 3'd5) exp_lo = a;
      check({tag, "_hi"}, u_if.o_HI, exp_hi);
      check({tag, "_lo"}, u_if.o_LO, exp_lo);
      check({tag, "_done"}, u_if.o_Done, 0);
      check({tag, "_busy"}, u_if.o_Busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int n, busy_n;
    u_if.i_Start     = 1'b0;
    u_if.i_Op        = 3'd0;
    u_if.i_SrcA      = '0;
    u_if.i_SrcB      = '0;
    u_if.i_Kill      = 1'b0;
    u_if.i_ReadHiLoD = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", u_if.o_HI, 0);
    check("rst_lo", u_if.o_LO, 0);
    check("rst_busy", u_if.o_Busy, 0);
    check("rst_done", u_if.o_Done, 0);
    rst_n = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 3'd0, -32'd3, 32'd7);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op("div_neg", 3'd2, -32'd7, 32'd2);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0);
    run_op("div_zero_neg", 3'd2, -32'd9, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi", 3'd4, 32'h1234, 32'd0);
    run_op("mtlo", 3'd5, 32'h5678, 32'd0);
    run_op("multu_9x5", 3'd1, 32'd9, 32'd5);
    run_op("multu_9x0", 3'd1, 32'd9, 32'd0);
    run_op("undef_op", 3'd7, 32'hDEAD_BEEF, 32'd1);

    // Stall while busy; the second issue must be dropped.
    @(negedge clk);
    u_if.i_Start = 1'b1; u_if.i_Op = 3'd1; u_if.i_SrcA = 32'd3; u_if.i_SrcB = 32'd5;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Start = 1'b0; u_if.i_ReadHiLoD = 1'b1;
    #1 check("stall_read", u_if.o_StallD, 1);
    @(posedge clk);
    @(negedge clk);
    u_if.i_ReadHiLoD = 1'b0;
    u_if.i_Start = 1'b1; u_if.i_Op = 3'd4; u_if.i_SrcA = 32'hABCD;
    #1 check("stall_start", u_if.o_StallD, 1);
    @(posedge clk);
    @(negedge clk);
    check("stall_start2", u_if.o_StallD, 1);
    u_if.i_Start = 1'b0;
    #1 check("stall_idle_req", u_if.o_StallD, 0);
    n = 0;
    while (!u_if.o_Done && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("stall_done_seen", u_if.o_Done, 1);
    exp_hi = 32'd0;
    exp_lo = 32'd15;
    check("stall_hi", u_if.o_HI, exp_hi);
    check("stall_lo", u_if.o_LO, exp_lo);

    // Kill at the 10th ITER edge.
    @(negedge clk);
    u_if.i_Start = 1'b1; u_if.i_Op = 3'd2; u_if.i_SrcA = 32'd1000; u_if.i_SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    u_if.i_Kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Kill = 1'b0;
    check("kill_busy", u_if.o_Busy, 0);
    check("kill_done", u_if.o_Done, 0);
    check("kill_hi", u_if.o_HI, exp_hi);
    check("kill_lo", u_if.o_LO, exp_lo);
    repeat (3) @(negedge clk);
    check("kill_done_late", u_if.o_Done, 0);

    // Kill beats start in IDLE.
    u_if.i_Start = 1'b1; u_if.i_Kill = 1'b1; u_if.i_Op = 3'd4; u_if.i_SrcA = 32'hFFFF;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Start = 1'b0; u_if.i_Kill = 1'b0;
    check("killstart_hi", u_if.o_HI, exp_hi);
    check("killstart_busy", u_if.o_Busy, 0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8) op = 3'(sel % 4);
      else if (sel == 8) op = 3'd4 + 3'($urandom_range(0, 1));
      else op = 3'd6 + 3'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op("rnd", op, a, b);
    end

    // Synchronous reset in the middle of a divide.
    @(negedge clk);
    u_if.i_Start = 1'b1; u_if.i_Op = 3'd2; u_if.i_SrcA = 32'd12345; u_if.i_SrcB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    u_if.i_Start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", u_if.o_Busy, 0);
    check("midrst_done", u_if.o_Done, 0);
    check("midrst_hi", u_if.o_HI, 0);
    check("midrst_lo", u_if.o_LO, 0);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    run_op("post_rst", 3'd1, 32'd6, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
